// File: rtl/nibble_eq_sequencer.sv
// nibble_eq_sequencer: multi-cycle equality compare of two NIBBLES*4-bit
// operands using a single shared 4-bit XNOR/AND equality slice, one nibble
// per cycle, LSB nibble first. Reports equal and the lowest mismatching
// nibble index.
//
// Optional build macro: NIBBLE_EQ_EARLY_EXIT_EN
//   defined   -> the first mismatching nibble ends the compare immediately
//   undefined -> all NIBBLES nibbles are always scanned (fixed latency)
module nibble_eq_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int IDXW    = $clog2((NIBBLES > 1) ? NIBBLES : 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic                   equal,
  output logic [IDXW-1:0]        first_diff
);

  localparam int W = 4 * NIBBLES;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_ra;
  logic [W-1:0]    r_rb;
  logic [IDXW-1:0] r_idx;
  logic            r_acc;
  logic            r_busy;
  logic            r_done;
  logic            r_equal;
  logic [IDXW-1:0] r_first_diff;

  // Shared 4-bit equality slice: select the current nibble of each operand,
  // XNOR bitwise, then AND-reduce. No full-width compare exists anywhere.
  logic [3:0] w_nib_a;
  logic [3:0] w_nib_b;
  logic [3:0] w_xnor;
  logic       w_eq;

  assign w_nib_a = r_ra[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_rb[{r_idx, 2'b00} +: 4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign w_xnor[gi] = ~(w_nib_a[gi] ^ w_nib_b[gi]);
    end
  endgenerate

  assign w_eq = &w_xnor;

  // Controller FSM: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ra         <= '0;
      r_rb         <= '0;
      r_idx        <= '0;
      r_acc        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_equal      <= 1'b0;
      r_first_diff <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ra         <= a;
            r_rb         <= b;
            r_idx        <= '0;
            r_acc        <= 1'b1;
            r_equal      <= 1'b0;
            r_first_diff <= '0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end

        RUN: begin
`ifdef NIBBLE_EQ_EARLY_EXIT_EN
          // Any mismatch is by construction the lowest one, so stop here.
          if (!w_eq) begin
            r_first_diff <= r_idx;
            r_equal      <= 1'b0;
            r_acc        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else if (r_idx == LAST_IDX) begin
            r_equal <= r_acc & w_eq;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`else
          // acc still high means no earlier mismatch: this one is the lowest.
          if (!w_eq && r_acc) begin
            r_first_diff <= r_idx;
          end
          r_acc <= r_acc & w_eq;
          if (r_idx == LAST_IDX) begin
            r_equal <= r_acc & w_eq;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`endif
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign equal      = r_equal;
  assign first_diff = r_first_diff;

endmodule

// File: tb/tb_nibble_eq_sequencer.sv
// Scoreboard bench for nibble_eq_sequencer (NIBBLES=4). The driver pushes the
// expected result plus the absolute edge after which done must be high; a
// separate monitor pops and compares on every done pulse.
module tb_nibble_eq_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        equal;
  logic [1:0]  first_diff;

  typedef struct {
    logic       eq;
    logic [1:0] fd;
    int         done_edge;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic prev_done;

`ifdef NIBBLE_EQ_EARLY_EXIT_EN
  localparam int LAT_N0 = 1;  // mismatch at nibble 0
  localparam int LAT_N1 = 2;  // lowest mismatch at nibble 1
`else
  localparam int LAT_N0 = 4;
  localparam int LAT_N1 = 4;
`endif

  nibble_eq_sequencer #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .first_diff (first_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_edge", cyc, e.done_edge);
        check("equal", int'(equal), int'(e.eq));
        check("first_diff", int'(first_diff), int'(e.fd));
        check("busy_at_done", int'(busy), 0);
      end
      if (prev_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_width: got done high 2 cycles expected 1 (cycle %0d)", cyc);
      end
    end
    prev_done = rst_n && done;
  end

  // Drive one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic push, input logic eq, input logic [1:0] fd,
                       input int lat);
    exp_t e;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.eq        = eq;
      e.fd        = fd;
      e.done_edge = cyc + 1 + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    $display("issue a=%h b=%h expect equal=%0d first_diff=%0d", av, bv, eq, fd);
  endtask

  // Wait (bounded) for the scoreboard to drain.
  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (k == 40) check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_err     = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_equal", int'(equal), 0);
    check("rst_first_diff", int'(first_diff), 0);
    rst_n = 1'b1;

    // 1: equal operands, busy window edges 0..3
    issue(16'h4444, 16'h4444, 1'b1, 1'b1, 2'd0, 4);
    for (int k = 0; k < 4; k++) begin
      check("t1_busy_high", int'(busy), 1);
      @(negedge clk);
    end
    check("t1_busy_low", int'(busy), 0);
    wait_drain("t1");

    // 2: mismatch at nibble 0
    issue(16'h000B, 16'h000A, 1'b1, 1'b0, 2'd0, LAT_N0);
    wait_drain("t2");

    // 3: mismatch only at top nibble
    issue(16'h8000, 16'h5000, 1'b1, 1'b0, 2'd3, 4);
    wait_drain("t3");

    // 4: mismatches at nibbles 1 and 3, lowest recorded
    issue(16'h1234, 16'hF2F4, 1'b1, 1'b0, 2'd1, LAT_N1);
    wait_drain("t4");

    // 5: start while busy is ignored
    issue(16'h7777, 16'h7777, 1'b1, 1'b1, 2'd0, 4);
    @(negedge clk);
    a     = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'h7777;
    wait_drain("t5");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_equal_hold", int'(equal), 1);
    end

    // 6: asynchronous reset mid-compare aborts without a done pulse
    issue(16'h1111, 16'h1111, 1'b0, 1'b1, 2'd0, 4);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy_async", int'(busy), 0);
    check("t6_done_async", int'(done), 0);
    check("t6_equal_async", int'(equal), 0);
    check("t6_fd_async", int'(first_diff), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0000, 1'b1, 1'b0, 2'd0, LAT_N0);
    wait_drain("t6");

    // Any stray done pulse after the last compare is caught by the monitor.
    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
